// File: rtl/write_arbiter_rr.sv
// write_arbiter_rr: round-robin arbiter and sequencer for the shared AXI
// write path (AW/W/B), two masters to five slaves plus a default slave.
// A grant is held from arbitration through the B handshake. W beats are
// counted against the latched AWLEN, and a sticky flag records any WLAST
// disagreement.
// Optional build macro WR_ARB_TIMEOUT_EN adds a watchdog. If a grant is
// held TIMEOUT_CYC cycles without finishing, the watchdog drops it and
// pulses timeout_err. Without the macro, timeout_err is tied low.
module write_arbiter_rr #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int LEN_W       = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             AWVALID_M0,
    input  logic             AWVALID_M1,
    input  logic [31:0]      AWADDR_M0,
    input  logic [31:0]      AWADDR_M1,
    input  logic [LEN_W-1:0] AWLEN_M0,
    input  logic [LEN_W-1:0] AWLEN_M1,
    input  logic             AWREADY_S,
    input  logic             WVALID_S,
    input  logic             WREADY_S,
    input  logic             WLAST_S,
    input  logic             BVALID_S,
    input  logic             BREADY_S,
    output logic [1:0]       grant,
    output logic [3:0]       aw_sel_id,
    output logic             sel_valid,
    output logic             wlast_err,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] SLV_ROM   = 3'd0;
    localparam logic [2:0] SLV_IM    = 3'd1;
    localparam logic [2:0] SLV_DM    = 3'd2;
    localparam logic [2:0] SLV_SCTRL = 3'd3;
    localparam logic [2:0] SLV_DRAM  = 3'd4;
    localparam logic [2:0] SLV_DFLT  = 3'd7;

    state_t           state;
    logic             last_grant;   // 0 = M0 won last, 1 = M1 won last
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_reg;

    logic             req_any;
    logic             pick_m1;
    logic [21:0]      req_addr_hi;
    logic [LEN_W-1:0] req_len;
    logic             aw_fire;
    logic             w_fire;
    logic             b_fire;
    logic             last_beat;

    // Address bits below the 1 KB SCTRL window never affect routing.
    logic unused_addr_lo;
    assign unused_addr_lo = ^{AWADDR_M0[9:0], AWADDR_M1[9:0]};

    // Slave decode on address bits [31:10]; the first matching window wins.
    function automatic logic [2:0] decode_slave(input logic [21:0] hi);
        logic [2:0] slv;
        if (hi[21:6] == 16'h0000)
            slv = SLV_ROM;
        else if (hi[21:6] == 16'h0001)
            slv = SLV_IM;
        else if (hi[21:6] == 16'h0002)
            slv = SLV_DM;
        else if (hi == 22'h040000)
            slv = SLV_SCTRL;
        else if (hi[21:11] == 11'h100)
            slv = SLV_DRAM;
        else
            slv = SLV_DFLT;
        return slv;
    endfunction

    assign req_any     = AWVALID_M0 || AWVALID_M1;
    // M1 wins when it is the only requester, or under contention when M0 won last.
    assign pick_m1     = AWVALID_M1 && (!AWVALID_M0 || !last_grant);
    assign req_addr_hi = pick_m1 ? AWADDR_M1[31:10] : AWADDR_M0[31:10];
    assign req_len     = pick_m1 ? AWLEN_M1 : AWLEN_M0;

    // Only the granted master's AWVALID counts toward the address handshake.
    assign aw_fire   = (aw_sel_id[3] ? AWVALID_M1 : AWVALID_M0) && AWREADY_S;
    assign w_fire    = WVALID_S && WREADY_S;
    assign b_fire    = BVALID_S && BREADY_S;
    assign last_beat = (beat_cnt == len_reg);

`ifdef WR_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // The watchdog limit has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_err = 1'b0;
`endif

    // Arbitration and burst sequencing FSM; all outputs are registered here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            grant      <= 2'b00;
            sel_valid  <= 1'b0;
            aw_sel_id  <= 4'b0000;
            beat_cnt   <= '0;
            len_reg    <= '0;
            wlast_err  <= 1'b0;
            last_grant <= 1'b1;
`ifdef WR_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef WR_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant      <= pick_m1 ? 2'b10 : 2'b01;
                        sel_valid  <= 1'b1;
                        aw_sel_id  <= {pick_m1, decode_slave(req_addr_hi)};
                        len_reg    <= req_len;
                        last_grant <= pick_m1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_fire) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // The beat count decides the burst end; WLAST is only cross-checked.
                        if (WLAST_S != last_beat)
                            wlast_err <= 1'b1;
                        if (last_beat)
                            state <= RESP;
                    end
                end
                RESP: begin
                    // A request seen in this same cycle is arbitrated only after IDLE is reached.
                    if (b_fire) begin
                        grant     <= 2'b00;
                        sel_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef WR_ARB_TIMEOUT_EN
            // The watchdog takes priority over any normal transition in the same cycle.
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_MAX) begin
                // last_grant is kept, so the other master wins the next contention.
                state       <= IDLE;
                grant       <= 2'b00;
                sel_valid   <= 1'b0;
                timeout_err <= 1'b1;
                wd_cnt      <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/write_arbiter_rr.md
Name: write_arbiter_rr

Overview:
- Round-robin arbiter and sequencer for the shared AXI write path: AW, W and B channels, 2 masters (M0, M1) to 5 slaves plus a default slave.
- Grants one master and holds the grant through the whole burst, from AW handshake to B handshake.
- Tracks W beats against the latched AWLEN and publishes a select/ID word that the bus mux and decoder use to route AW/W/B.
- Sits beside the read arbiter in the AXI interconnect.

Parameters:
- TIMEOUT_CYC, 1024: cycle limit for a held grant without B handshake (used only by the optional feature).
- LEN_W, 4: width of the AWLEN and beat counter.

Ports:
- ACLK  input  1  bus clock, rising edge.
- ARESET  input  1  synchronous, active-high reset.
- AWVALID_M0 / AWVALID_M1  input  1  master write-address requests.
- AWADDR_M0 / AWADDR_M1  input  32  master write addresses.
- AWLEN_M0 / AWLEN_M1  input  LEN_W  burst length minus 1.
- AWREADY_S  input  1  AWREADY of the currently selected slave.
- WVALID_S, WREADY_S, WLAST_S  input  1 each  muxed W-channel handshake signals at the slave side.
- BVALID_S, BREADY_S  input  1 each  muxed B-channel handshake signals.
- grant  output  2  2'b00 none, 2'b01 M0, 2'b10 M1.
- aw_sel_id  output  4  bit[3] = master (0 = M0, 1 = M1); bits[2:0] = slave: 0 ROM, 1 IM, 2 DM, 3 SCTRL, 4 DRAM, 7 default.
- sel_valid  output  1  aw_sel_id is meaningful.
- wlast_err  output  1  sticky WLAST/beat-count mismatch flag.
- timeout_err  output  1  one-cycle pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - state=IDLE; grant=2'b00; sel_valid=0; aw_sel_id=4'b0000.
  - beat_cnt=0; len_reg=0; wlast_err=0; timeout_err=0.
  - last_grant=M1, so M0 wins the first contention.
  - Reset mid-burst aborts immediately; no handshake completion is required.
- States: IDLE, ADDR, DATA, RESP. grant and sel_valid are registered; the grant asserts 1 cycle after the request is seen in IDLE.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant the master opposite last_grant.
  - On grant: latch that master's AWADDR-decoded slave into aw_sel_id and its AWLEN into len_reg; set last_grant; go to ADDR.
  - No request: stay in IDLE.
- ADDR: wait for AWVALID_Mx (granted master) && AWREADY_S; then beat_cnt=0, go to DATA. Requests from the other master are ignored.
- DATA:
  - Each WVALID_S && WREADY_S increments beat_cnt (LEN_W bits, wraps).
  - Last beat is the beat where beat_cnt==len_reg: go to RESP.
  - If WLAST_S on that beat differs from (beat_cnt==len_reg), set wlast_err (sticky until reset). The state still follows the count.
- RESP: on BVALID_S && BREADY_S, clear grant and sel_valid and go to IDLE. Re-arbitration happens the following cycle, so there is a minimum of 1 idle cycle between bursts.
- Address decode, first match wins:
  - [31:16]==16'h0000 → ROM.
  - 16'h0001 → IM.
  - 16'h0002 → DM.
  - [31:10]==22'h040000 (0x1000_0000–0x1000_03FF) → SCTRL.
  - [31:21]==11'h100 (0x2000_0000–0x201F_FFFF) → DRAM.
  - Otherwise → default (7).
- Simultaneous events:
  - B handshake and a new request in the same cycle: the request waits for IDLE.
  - A single-beat burst (len 0) goes DATA→RESP on its first beat.

Optional Feature:
- Macro: WR_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every grant and counts each cycle while state≠IDLE.
  - On reaching TIMEOUT_CYC-1: force state=IDLE, clear grant, pulse timeout_err for 1 cycle. last_grant is unchanged, so the other master gets the next contention.
- Undefined: no counter; timeout_err is constant 0; a grant is held indefinitely.

Test Plan:
- Reset, then AWVALID_M0=AWVALID_M1=1, both AWADDR=0x0001_0000, AWLEN=0 → grant=01 and aw_sel_id=4'b0001 after 1 cycle. After the full burst, M1 is granted next with aw_sel_id=4'b1001.
- M1 alone, AWADDR=0x2000_0040, AWLEN=3, 4 W beats with WLAST on the 4th, then B → aw_sel_id=4'b1100, grant held for 4 beats, back to IDLE the cycle after B, wlast_err=0.
- M0, AWADDR=0x1000_0400, AWLEN=1 → aw_sel_id=4'b0111 (default). Drive WLAST on beat 0 → wlast_err=1 and stays 1.
- ARESET asserted in DATA after 2 of 4 beats → next cycle grant=00, sel_valid=0, state IDLE; a new M0 request is granted normally.
- Continuous M0 and M1 requests over 6 bursts → grant sequence M0,M1,M0,M1,M0,M1; never two consecutive grants to one master.
- WR_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, BVALID never asserted → timeout_err pulses exactly once, 16 cycles after the grant; grant=00 the same cycle the pulse appears.
